// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default build is round-robin.
module alu_arbiter #(
  parameter int unsigned    WIDTH   = 32,
  parameter int unsigned    OPW     = 4,
  parameter logic [OPW-1:0] IDLE_OP = 4'b1001
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // Port 0: execute stage
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [OPW-1:0]   req0_op_i,
  output logic             rsp0_valid_o,
  input  logic             rsp0_ready_i,
  output logic [WIDTH-1:0] rsp0_c_o,
  output logic             rsp0_zero_o,
  // Port 1: address/branch unit
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic [OPW-1:0]   req1_op_i,
  output logic             rsp1_valid_o,
  input  logic             rsp1_ready_i,
  output logic [WIDTH-1:0] rsp1_c_o,
  output logic             rsp1_zero_o,
  // Shared ALU
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [OPW-1:0]   alu_op_o,
  input  logic [WIDTH-1:0] alu_c_i,
  input  logic             alu_zero_i
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSetup = 2'd1;
  localparam logic [1:0] StExec  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;

  logic             rsp0_valid_q, rsp0_valid_d;
  logic [WIDTH-1:0] rsp0_c_q, rsp0_c_d;
  logic             rsp0_zero_q, rsp0_zero_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp1_c_q, rsp1_c_d;
  logic             rsp1_zero_q, rsp1_zero_d;

  logic             any_valid;
  logic             win_id;
  logic             accept;
  logic             rsp_hs;
  logic [WIDTH-1:0] cap_c;

  assign any_valid = req0_valid_i | req1_valid_i;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    win_id = ~req0_valid_i;
  end
`else
  // Pointer holds the id granted last; it loses a tie.
  logic last_q, last_d;

  always_comb begin
    if (req0_valid_i && req1_valid_i) begin
      win_id = ~last_q;
    end else begin
      win_id = ~req0_valid_i;
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = win_id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Ready is gated by reset so nothing is accepted in the reset cycle.
  assign accept       = (state_q == StIdle) && !rst_i && any_valid;
  assign req0_ready_o = accept && !win_id;
  assign req1_ready_o = accept && win_id;

  assign rsp_hs = gnt_q ? rsp1_ready_i : rsp0_ready_i;

  // An IDLE_OP request never changes the opcode, so its result is defined as zero.
  assign cap_c = (op_q == IDLE_OP) ? '0 : alu_c_i;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp0_c_d     = rsp0_c_q;
    rsp0_zero_d  = rsp0_zero_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_c_d     = rsp1_c_q;
    rsp1_zero_d  = rsp1_zero_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSetup;
          gnt_d   = win_id;
          a_d     = win_id ? req1_a_i : req0_a_i;
          b_d     = win_id ? req1_b_i : req0_b_i;
          op_d    = win_id ? req1_op_i : req0_op_i;
        end
      end
      StSetup: begin
        state_d = StExec;
      end
      StExec: begin
        state_d = StResp;
        if (gnt_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_c_d     = cap_c;
          rsp1_zero_d  = alu_zero_i;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_c_d     = cap_c;
          rsp0_zero_d  = alu_zero_i;
        end
      end
      StResp: begin
        if (rsp_hs) begin
          state_d = StIdle;
          if (gnt_q) begin
            rsp1_valid_d = 1'b0;
          end else begin
            rsp0_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      gnt_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= IDLE_OP;
      rsp0_valid_q <= 1'b0;
      rsp0_c_q     <= '0;
      rsp0_zero_q  <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_c_q     <= '0;
      rsp1_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_c_q     <= rsp0_c_d;
      rsp0_zero_q  <= rsp0_zero_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_c_q     <= rsp1_c_d;
      rsp1_zero_q  <= rsp1_zero_d;
    end
  end

  // Operand registers load on accept, so the ALU sees them from SETUP onward.
  assign alu_a_o  = a_q;
  assign alu_b_o  = b_q;
  assign alu_op_o = (state_q == StExec) ? op_q : IDLE_OP;

  assign rsp0_valid_o = rsp0_valid_q;
  assign rsp0_c_o     = rsp0_c_q;
  assign rsp0_zero_o  = rsp0_zero_q;
  assign rsp1_valid_o = rsp1_valid_q;
  assign rsp1_c_o     = rsp1_c_q;
  assign rsp1_zero_o  = rsp1_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of grant order, latency and results.
module tb_alu_arbiter;

  localparam int unsigned W       = 32;
  localparam logic [3:0]  IDLE_OP = 4'b1001;

  logic         clk = 1'b0;
  logic         rst;
  logic         v0, v1, r0, r1, rr0, rr1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [3:0]   op0, op1;
  logic         rv0, rv1, rz0, rz1;
  logic [W-1:0] rc0, rc1;
  logic [W-1:0] alu_a, alu_b, alu_c;
  logic [3:0]   alu_op;
  logic         alu_zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .OPW(4), .IDLE_OP(IDLE_OP)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (v0),
    .req0_ready_o (r0),
    .req0_a_i     (a0),
    .req0_b_i     (b0),
    .req0_op_i    (op0),
    .rsp0_valid_o (rv0),
    .rsp0_ready_i (rr0),
    .rsp0_c_o     (rc0),
    .rsp0_zero_o  (rz0),
    .req1_valid_i (v1),
    .req1_ready_o (r1),
    .req1_a_i     (a1),
    .req1_b_i     (b1),
    .req1_op_i    (op1),
    .rsp1_valid_o (rv1),
    .rsp1_ready_i (rr1),
    .rsp1_c_o     (rc1),
    .rsp1_zero_o  (rz1),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .alu_c_i      (alu_c),
    .alu_zero_i   (alu_zero)
  );

  // Stand-in ALU; 1001 deliberately returns a non-zero value so the arbiter's forcing shows.
  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      4'b0000: return a;
      4'b0001: return a & b;
      4'b0010: return a | b;
      4'b0011: return a ^ b;
      4'b0100: return ~(a | b);
      4'b0101: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'b1000: return a << b[4:0];
      4'b1001: return a | b;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_c    = alu_fn(alu_op, alu_a, alu_b);
    alu_zero = (alu_a == alu_b);
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model state
  bit           m_busy;
  int           m_age;
  int           m_port;
  bit           m_last;
  bit           m_post_rst;
  logic [W-1:0] m_a, m_b, m_c;
  logic [3:0]   m_op;
  logic         m_z;
  logic [W-1:0] last_c [2];
  logic         last_z [2];
  int           grants [$];

  task automatic model_step();
    int win;
    if (rst) begin
      check("ready0_in_rst", W'(r0), W'(0));
      check("ready1_in_rst", W'(r1), W'(0));
      m_busy     = 0;
      m_last     = 1;
      m_post_rst = 1;
      return;
    end
    if (r0 || r1) grants.push_back(r1 ? 1 : 0);
    if (m_post_rst) begin
      check("rst_alu_a", alu_a, '0);
      check("rst_alu_b", alu_b, '0);
      check("rst_rsp0_c", rc0, '0);
      check("rst_rsp1_c", rc1, '0);
      check("rst_rsp0_zero", W'(rz0), W'(0));
      check("rst_rsp1_zero", W'(rz1), W'(0));
      m_post_rst = 0;
    end
    if (!m_busy) begin
      win = -1;
      if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        win = 0;
`else
        win = m_last ? 0 : 1;
`endif
      end else if (v0) begin
        win = 0;
      end else if (v1) begin
        win = 1;
      end
      check("idle_ready0", W'(r0), W'(win == 0));
      check("idle_ready1", W'(r1), W'(win == 1));
      check("idle_alu_op", W'(alu_op), W'(IDLE_OP));
      check("idle_rsp0_valid", W'(rv0), W'(0));
      check("idle_rsp1_valid", W'(rv1), W'(0));
      if (win >= 0) begin
        m_busy = 1;
        m_age  = 0;
        m_port = win;
        m_a    = (win == 1) ? a1 : a0;
        m_b    = (win == 1) ? b1 : b0;
        m_op   = (win == 1) ? op1 : op0;
        m_c    = (m_op == IDLE_OP) ? '0 : alu_fn(m_op, m_a, m_b);
        m_z    = (m_a == m_b);
        m_last = (win == 1);
      end
    end else begin
      m_age++;
      check("busy_ready0", W'(r0), W'(0));
      check("busy_ready1", W'(r1), W'(0));
      check("busy_alu_a", alu_a, m_a);
      check("busy_alu_b", alu_b, m_b);
      if (m_age < 3) begin
        check("issue_alu_op", W'(alu_op), W'((m_age == 2) ? m_op : IDLE_OP));
        check("early_rsp0_valid", W'(rv0), W'(0));
        check("early_rsp1_valid", W'(rv1), W'(0));
      end else begin
        check("resp_alu_op", W'(alu_op), W'(IDLE_OP));
        check("resp_rsp0_valid", W'(rv0), W'(m_port == 0));
        check("resp_rsp1_valid", W'(rv1), W'(m_port == 1));
        check("resp_c", (m_port == 1) ? rc1 : rc0, m_c);
        check("resp_zero", W'((m_port == 1) ? rz1 : rz0), W'(m_z));
        if ((m_port == 1) ? rr1 : rr0) begin
          last_c[m_port] = (m_port == 1) ? rc1 : rc0;
          last_z[m_port] = (m_port == 1) ? rz1 : rz0;
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (!m_busy) return;
      tick();
    end
    check("drain_timeout", W'(m_busy), W'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
    a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;

    // Single add on port 0
    v0 = 1; a0 = 5; b0 = 3; op0 = 4'b0101;
    tick();
    v0 = 0;
    drain(20);
    check("plan_add_c", last_c[0], W'(8));
    check("plan_add_zero", W'(last_z[0]), W'(0));

    // Same opcode twice in a row
    v0 = 1; a0 = 7; b0 = 7; op0 = 4'b0110;
    tick();
    a0 = 9; b0 = 2;
    drain(20);
    check("b2b_first_c", last_c[0], W'(0));
    check("b2b_first_zero", W'(last_z[0]), W'(1));
    tick();
    v0 = 0;
    drain(20);
    check("b2b_second_c", last_c[0], W'(7));
    check("b2b_second_zero", W'(last_z[0]), W'(0));

    // Contention from a fresh pointer
    do_reset();
    grants.delete();
    v0 = 1; a0 = 'hFF; b0 = 'h0F; op0 = 4'b0001;
    v1 = 1; a1 = 'hF0; b1 = 'h0F; op1 = 4'b0010;
    repeat (16) tick();
    v0 = 0; v1 = 0;
    drain(20);
    check("cont_grant_count", W'(grants.size()), W'(4));
    for (int i = 0; i < grants.size() && i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("cont_grant_id", W'(grants[i]), W'(0));
`else
      check("cont_grant_id", W'(grants[i]), W'(i % 2));
`endif
    end
    check("cont_port0_c", last_c[0], W'('h0F));
`ifndef ALU_ARB_FIXED_PRIO_EN
    check("cont_port1_c", last_c[1], W'('hFF));
`endif

    // Backpressure on port 1 while port 0 waits
    v1 = 1; a1 = 40; b1 = 2; op1 = 4'b0110; rr1 = 0;
    tick();
    v1 = 0; v0 = 1; a0 = 3; b0 = 4; op0 = 4'b0011;
    repeat (7) tick();
    rr1 = 1;
    grants.delete();
    tick();
    tick();
    v0 = 0;
    check("bp_next_grant", W'(grants.size()), W'(1));
    if (grants.size() > 0) check("bp_next_grant_id", W'(grants[0]), W'(0));
    drain(20);
    check("bp_port1_c", last_c[1], W'(38));
    check("bp_port0_c", last_c[0], W'(7));

    // Reset while in EXEC
    v0 = 1; a0 = 11; b0 = 22; op0 = 4'b0101;
    tick();
    v0 = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    repeat (6) tick();

    // IDLE_OP and an undefined opcode
    v0 = 1; a0 = 5; b0 = 3; op0 = 4'b1001;
    tick();
    v0 = 0;
    drain(20);
    check("op1001_c", last_c[0], W'(0));
    v1 = 1; a1 = 6; b1 = 6; op1 = 4'b1111;
    tick();
    v1 = 0;
    drain(20);
    check("op1111_c", last_c[1], W'(0));
    check("op1111_zero", W'(last_z[1]), W'(1));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 127) == 0);
      v0  = ($urandom_range(0, 2) != 0);
      v1  = ($urandom_range(0, 2) != 0);
      rr0 = ($urandom_range(0, 4) < 3);
      rr1 = ($urandom_range(0, 4) < 3);
      a0  = $urandom();
      b0  = ($urandom_range(0, 3) == 0) ? a0 : $urandom();
      a1  = $urandom();
      b1  = ($urandom_range(0, 3) == 0) ? a1 : $urandom();
      op0 = 4'($urandom_range(0, 15));
      op1 = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 0; v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters: the execute stage (port 0) and the address/branch unit (port 1). It arbitrates incoming operations, sequences operands and opcode onto the ALU, and captures the result and zero flag. It returns the captured result to the winning requester over a valid/ready handshake. It sits between the requesters and the ALU instance and is the only driver of the ALU inputs.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width
- `OPW`, 4, opcode width
- `IDLE_OP`, 4'b1001, opcode driven while no operation is executing (ALU "clear output")

Ports:
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — synchronous, active-high reset
- `req0_valid` / `req1_valid` in 1 — operation request
- `req0_ready` / `req1_ready` out 1 — request accepted this cycle
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in WIDTH — operands
- `req0_op` / `req1_op` in OPW — ALU opcode
- `rsp0_valid` / `rsp1_valid` out 1 — result available
- `rsp0_ready` / `rsp1_ready` in 1 — requester consumes result
- `rsp0_c` / `rsp1_c` out WIDTH — captured result
- `rsp0_zero` / `rsp1_zero` out 1 — captured A==B flag
- `alu_a`, `alu_b` out WIDTH — to ALU operands
- `alu_op` out OPW — to ALU opcode
- `alu_c` in WIDTH, `alu_zero` in 1 — from ALU

## Operation
- The FSM has four states: IDLE, SETUP, EXEC, RESP.
- IDLE:
  - `alu_op`=IDLE_OP.
  - Ready is asserted combinationally to at most one requester: the arbitration winner among valid requests.
  - On valid&ready, latch a, b, op and the grant id, then go to SETUP.
- SETUP:
  - `alu_a`/`alu_b` are driven from the latched operands; `alu_op` stays IDLE_OP.
  - Operands settle before the opcode changes, so the ALU sees an opcode transition on every issue.
  - Always go to EXEC.
- EXEC:
  - `alu_op` = latched op.
  - At the end of the cycle, capture `alu_c` and `alu_zero` into the winner's response register, then go to RESP.
  - If latched op equals IDLE_OP, no opcode transition occurs. The captured result is forced to 0; zero is still captured from `alu_zero`.
- RESP:
  - The winner's `rspN_valid`=1, holding c/zero stable until `rspN_ready`=1.
  - `alu_op`=IDLE_OP; `alu_a`/`alu_b` hold their values.
  - On handshake, clear valid and go to IDLE.
- Arbitration is round-robin:
  - A one-bit last-grant pointer is updated on each accept.
  - When both requesters are valid, the one not granted last wins.
  - After reset the pointer favours port 0.
- Opcodes are passed through unchecked. Undefined codes (1010–1111) yield whatever the ALU produces (0).
- Only one operation is in flight; no request is accepted outside IDLE. Both ready outputs are 0 in SETUP/EXEC/RESP.
- A requester may drop valid before acceptance without effect.

## Timing
- Reset values: `req*_ready`=0 registered-path-free in reset cycle, `rsp*_valid`=0, `rsp*_c`=0, `rsp*_zero`=0, `alu_a`=0, `alu_b`=0, `alu_op`=IDLE_OP, state=IDLE, pointer=port 1 last-granted.
- Latency: accept at cycle T → SETUP T+1 → EXEC T+2 → `rsp_valid` high from T+3.
- If `rsp_ready` is already high at T+3, return to IDLE at T+4, and the next accept is possible in T+4. Minimum issue interval is 4 cycles.
- Response backpressure stalls the block in RESP indefinitely.
- `rst` asserted in any state: next cycle is IDLE with all outputs at their reset values. The in-flight operation and pending response are discarded, and the pointer is reset.
- `rst` takes priority over a simultaneous handshake.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority; port 0 always wins when both requesters are valid, and the pointer is not implemented.
  - Undefined (default): round-robin as above.

## Test plan
- Single op: port 0 a=5, b=3, op=0101 → req0_ready at T, alu_op 1001 at T+1, 0101 at T+2; rsp0_valid at T+3 with c=8, zero=0.
- Back-to-back same opcode: port 0 issues 0110 (7,7), then 0110 (9,2) → rsp0_c=0 with zero=1, then rsp0_c=7 with zero=0. Verifies the IDLE_OP re-insertion.
- Contention: both valid continuously (port 0: 0001 on FF/0F; port 1: 0010 on F0/0F) → grants alternate 0,1,0,1 and results 0F, FF. With `ALU_ARB_FIXED_PRIO_EN`, port 0 is granted every time.
- Backpressure: rsp1_ready low for 5 cycles after rsp1_valid → rsp1_c/zero stable, req0_ready stays 0, and port 0 is accepted the cycle after the rsp1 handshake.
- Reset mid-op: rst in EXEC → next cycle state IDLE, rsp*_valid=0, alu_op=1001, and no response is ever delivered for the dropped op.
- Opcode 1001 and 1111 requested → rsp_c=0 within 3-cycle latency; the FSM returns to IDLE normally.
